// File: rtl/stream_encryptor.sv
// Purpose: XORs 64-bit plaintext blocks with a 64-bit Fibonacci LFSR keystream on the transmit side.
// Latency: 1 cycle from accept to a registered chiper with chiper_valid; 1 block/cycle sustained.
// Backpressure: plain_ready drops while a held block is stalled or seed_load is asserted; the held block stays stable.
module stream_encryptor #(
  parameter logic [63:0] SEED  = 64'h0000_0000_0000_0001,
  parameter int          CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [63:0]      seed_in,
  input  logic [63:0]      plain,
  input  logic             plain_valid,
  output logic             plain_ready,
  output logic [63:0]      chiper,
  output logic             chiper_valid,
  input  logic             chiper_ready,
  output logic [CNT_W-1:0] blk_count,
  output logic             busy
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state;
  logic [63:0] lfsr;
  logic [63:0] lfsr_next;
  logic [63:0] seed_eff;
  logic        accept;
  logic        deliver;
  logic        seed_take;

  // Fibonacci step with taps 64,63,61,60 (bits 63,62,60,59); an all-zero seed is swapped for SEED to avoid lockup.
  always_comb begin
    lfsr_next = {lfsr[62:0], lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59]};
    seed_eff  = (seed_in == 64'd0) ? SEED : seed_in;
  end

  // Handshake decode: the output slot is free when empty or being drained this cycle;
  // a seed load blocks accepts so the keystream never loads and steps in the same cycle.
  always_comb begin
    plain_ready = !rst && ((state == EMPTY) || chiper_ready) && !seed_load;
    accept      = plain_valid && plain_ready;
    deliver     = (state == FULL) && chiper_ready;
    seed_take   = seed_load && ((state == EMPTY) || chiper_ready);
  end

  // Output-stage FSM with registered chiper/valid/busy, keystream state and block counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= EMPTY;
      chiper       <= 64'd0;
      chiper_valid <= 1'b0;
      busy         <= 1'b0;
      lfsr         <= SEED;
      blk_count    <= '0;
    end else begin
      if (accept) begin
        // Keystream word is the LFSR state in the accept cycle; step once per block.
        state        <= FULL;
        chiper       <= plain ^ lfsr;
        chiper_valid <= 1'b1;
        busy         <= 1'b1;
        lfsr         <= lfsr_next;
        blk_count    <= blk_count + CNT_W'(1);
      end else begin
        if (deliver) begin
          // Drained with nothing replacing it: chiper keeps its last value.
          state        <= EMPTY;
          chiper_valid <= 1'b0;
          busy         <= 1'b0;
        end
        if (seed_take) begin
          lfsr      <= seed_eff;
          blk_count <= '0;
        end
      end
    end
  end

endmodule

// File: doc/stream_encryptor.md
Name: stream_encryptor

Overview:
- Transmit-side counterpart of the keystream decryption path: encrypts 64-bit plaintext blocks by XOR with a 64-bit LFSR keystream.
- The keystream generator is internal, seeded, and advances once per accepted block. A receiver seeded identically recovers plaintext block-for-block.
- Sits between the plaintext source and the link. Valid/ready handshakes on both sides, one registered output stage.

Parameters:
- SEED, 64'h0000_0000_0000_0001, default LFSR state after reset and the substitute for an all-zero seed load.
- CNT_W, 32, width of the accepted-block counter.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- seed_load, input, 1, load seed_in into the LFSR (only honoured while no block is held).
- seed_in, input, 64, new keystream seed.
- plain, input, 64, plaintext block.
- plain_valid, input, 1, plain is valid.
- plain_ready, output, 1, encryptor can accept a block this cycle.
- chiper, output, 64, ciphertext block (registered).
- chiper_valid, output, 1, chiper holds an undelivered block.
- chiper_ready, input, 1, downstream accepts chiper.
- blk_count, output, CNT_W, number of blocks accepted since reset or last seed load.
- busy, output, 1, high while chiper_valid is high.

Behaviour:
- Reset, sampled at a clk edge while rst=1:
  - LFSR = SEED; chiper = 0; chiper_valid = 0; blk_count = 0; busy = 0.
  - rst overrides every other input and discards any held block. plain_ready is 0 while rst is high.
- LFSR:
  - 64-bit Fibonacci, taps 64,63,61,60.
  - next = {s[62:0], s[63]^s[62]^s[60]^s[59]}.
  - The keystream word for a block is the LFSR state in the accept cycle. The LFSR steps exactly once per accepted block and never otherwise.
- Handshake:
  - plain_ready = !rst && (!chiper_valid || chiper_ready) && !seed_load.
  - Accept happens when plain_valid && plain_ready. Latency is 1 cycle: on the accept edge, chiper <= plain ^ lfsr, chiper_valid <= 1, lfsr <= next, blk_count <= blk_count+1.
  - Delivery happens when chiper_valid && chiper_ready. If there is no simultaneous accept, chiper_valid <= 0 and chiper holds its last value.
  - Simultaneous delivery and accept: chiper is replaced with the new block and chiper_valid stays 1. Throughput is 1 block/cycle with no bubble.
  - Stall: while chiper_valid && !chiper_ready, chiper and chiper_valid are held stable and plain_ready = 0.
- State machine, 2 states:
  - EMPTY (chiper_valid=0): on accept, go to FULL.
  - FULL (chiper_valid=1): stay FULL on stall or on delivery+accept; go to EMPTY on delivery without accept.
  - busy = (state==FULL).
- Seed load:
  - Honoured only when state==EMPTY, or in FULL when the held block is delivered that same cycle. Otherwise it is ignored and has no effect.
  - When honoured: lfsr <= (seed_in==0) ? SEED : seed_in, and blk_count <= 0.
  - The all-zero seed is never loaded, which prevents lockup.
  - plain_ready is forced to 0 while seed_load=1, so a seed load and a block accept never occur in the same cycle.
- blk_count wraps modulo 2^CNT_W with no saturation. The LFSR is unaffected by the wrap.
- chiper must never change while chiper_valid=1 && chiper_ready=0.

Test Plan:
- Reset then sequence:
  - Stimulus: rst=1 for 3 cycles, release; push plain=0 three times with chiper_ready=1.
  - Required: chiper = 64'h1, 64'h2, 64'h4 on consecutive cycles; blk_count=3; plain_ready=0 during reset.
- Known vector:
  - Stimulus: after reset, plain=64'd8388761.
  - Required: chiper=64'd8388760 one cycle later.
  - Stimulus: a second block with plain=64'd8388761.
  - Required: chiper=64'd8388763.
- Backpressure:
  - Stimulus: hold chiper_ready=0 for 5 cycles with plain_valid=1.
  - Required: chiper stable, plain_ready=0, blk_count unchanged, LFSR not stepped.
  - Stimulus: release chiper_ready.
  - Required: the next block uses the next keystream word (no skip, no repeat).
- Seed load:
  - Stimulus: in EMPTY, seed_load=1 with seed_in=64'h8000_0000_0000_0000; then plain=0.
  - Required: chiper=64'h8000_0000_0000_0000; the following block's keystream is 64'h1 (fb=1); blk_count restarts from 0.
  - Stimulus: seed_in=0.
  - Required: the LFSR reloads SEED.
- Seed load while stalled:
  - Stimulus: seed_load=1 in FULL with chiper_ready=0.
  - Required: the load is ignored and the subsequent keystream continues the old sequence.
- Round trip:
  - Stimulus: 1000 random blocks with random valid/ready; feed chiper to a receive-side XOR using the same seed and LFSR stepped per block.
  - Required: recovered text equals the input stream exactly; blk_count=1000.
